// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of a registered arithmetic unit: accepts one op, pulses the
// unit enable once, captures the result (or a div-by-zero / watchdog error) and holds it for the consumer.
module alu_cmd_sequencer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_fun,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic [DATA_WIDTH-1:0] in1,
    output logic [DATA_WIDTH-1:0] in2,
    output logic [1:0]            arith_fun,
    output logic                  arith_en,
    input  logic [DATA_WIDTH-1:0] arith_out,
    input  logic                  arith_cout,
    input  logic                  arith_flag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_cout,
    output logic                  rsp_err
);

    localparam int unsigned CNT_W   = $clog2(TIMEOUT) + 1;
    localparam logic [1:0]  FUN_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   rsp_data_next;
    logic                    rsp_cout_next;
    logic                    rsp_err_next;

    // Only IDLE accepts, and never while reset is held.
    assign cmd_ready = (state == S_IDLE) && !rst;

    // Next-state, watchdog and response-capture decisions.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        accept        = 1'b0;
        rsp_data_next = rsp_data;
        rsp_cout_next = rsp_cout;
        rsp_err_next  = rsp_err;

        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if ((cmd_fun == FUN_DIV) && (cmd_b == '0)) begin
                        rsp_data_next = '0;
                        rsp_cout_next = 1'b0;
                        rsp_err_next  = 1'b1;
                        state_next    = S_RESP;
                    end else begin
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (arith_flag) begin
                    rsp_data_next = arith_out;
                    rsp_cout_next = arith_cout;
                    rsp_err_next  = 1'b0;
                    state_next    = S_RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_next = '0;
                    rsp_cout_next = 1'b0;
                    rsp_err_next  = 1'b1;
                    state_next    = S_RESP;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, operand and response registers; enable/valid are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            in1       <= '0;
            in2       <= '0;
            arith_fun <= 2'b00;
            arith_en  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            arith_en  <= (state_next == S_ISSUE);
            rsp_valid <= (state_next == S_RESP);
            rsp_data  <= rsp_data_next;
            rsp_cout  <= rsp_cout_next;
            rsp_err   <= rsp_err_next;
            if (accept) begin
                in1       <= cmd_a;
                in2       <= cmd_b;
                arith_fun <= cmd_fun;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed cases plus randomized commands,
// with a bench-side arithmetic unit whose flag latency can be delayed or suppressed.
module tb_alu_cmd_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_fun;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic [1:0]    arith_fun;
    logic          arith_en;
    logic [DW-1:0] arith_out  = '0;
    logic          arith_cout = 1'b0;
    logic          arith_flag = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_cout;
    logic          rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    int u_delay = 0;
    bit u_sup   = 1'b0;
    int u_wait  = 0;

    alu_cmd_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_fun    (cmd_fun),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .in1        (in1),
        .in2        (in2),
        .arith_fun  (arith_fun),
        .arith_en   (arith_en),
        .arith_out  (arith_out),
        .arith_cout (arith_cout),
        .arith_flag (arith_flag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_cout   (rsp_cout),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Arithmetic result as {carry/borrow, value}.
    function automatic logic [DW:0] golden(input logic [1:0] f, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        logic [DW:0] r;
        case (f)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {(a < b), DW'(a - b)};
            2'b10:   r = {1'b0, DW'(a * b)};
            default: r = (b == '0) ? '0 : {1'b0, DW'(a / b)};
        endcase
        return r;
    endfunction

    // Bench arithmetic unit: registers the result on enable, raises the flag after u_delay extra cycles.
    always @(posedge clk) begin
        arith_flag <= 1'b0;
        if (arith_en) begin
            {arith_cout, arith_out} <= golden(arith_fun, in1, in2);
            if (!u_sup && u_delay == 0) arith_flag <= 1'b1;
            u_wait <= (u_sup || u_delay == 0) ? 0 : u_delay;
        end else if (u_wait > 0) begin
            u_wait <= u_wait - 1;
            if (u_wait == 1) arith_flag <= 1'b1;
        end
    end

    // One command from accept to response handshake; called at a negedge with the DUT idle.
    task automatic do_cmd(input logic [1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int dly, input bit sup, input int hold,
                          input bit use_exp, input logic [DW-1:0] exp_data, input logic exp_cout);
        logic [DW:0]   g;
        logic [DW-1:0] ed;
        logic          ec;
        bit            dz;
        bit            ok;
        int            lat;
        dz  = (f == 2'b11) && (b == '0);
        ok  = !dz && !sup && (dly <= int'(TO) - 1);
        g   = golden(f, a, b);
        ed  = use_exp ? exp_data : g[DW-1:0];
        ec  = use_exp ? exp_cout : g[DW];
        if (!ok) begin
            ed = '0;
            ec = 1'b0;
        end
        lat = dz ? 1 : (ok ? 3 + dly : 2 + int'(TO));

        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_fun   = f;
        cmd_a     = a;
        cmd_b     = b;
        u_delay   = dly;
        u_sup     = sup;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a     = DW'($urandom);
        cmd_b     = DW'($urandom);
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge clk);
            check("arith_en", 32'(arith_en), 32'((c == 1) && !dz));
            check("rsp_valid_rise", 32'(rsp_valid), 32'(c == lat));
            check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            if (c == 1) begin
                check("in1", 32'(in1), 32'(a));
                check("in2", 32'(in2), 32'(b));
                check("arith_fun", 32'(arith_fun), 32'(f));
            end
        end
        check("rsp_data", 32'(rsp_data), 32'(ed));
        check("rsp_cout", 32'(rsp_cout), 32'(ec));
        check("rsp_err", 32'(rsp_err), 32'(!ok));
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", 32'(rsp_data), 32'(ed));
            check("hold_cout_err", 32'({rsp_cout, rsp_err}), 32'({ec, !ok}));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        // Release with a colliding command that must not be taken this cycle.
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_a     = ~a;
        cmd_b     = ~b;
        cmd_fun   = ~f;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("release_valid", 32'(rsp_valid), 32'd0);
        check("release_ready", 32'(cmd_ready), 32'd1);
        check("collide_in1", 32'(in1), 32'(a));
    endtask

    task automatic reset_mid_wait();
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_fun   = 2'b00;
        cmd_a     = 16'h1111;
        cmd_b     = 16'h2222;
        u_delay   = 1;
        u_sup     = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rmw_arith_en", 32'(arith_en), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rmw_ready_in_rst", 32'(cmd_ready), 32'd0);
        check("rmw_ctrl_zero", 32'({rsp_valid, arith_en, rsp_cout, rsp_err}), 32'd0);
        check("rmw_ops_zero", {in1, in2}, 32'd0);
        check("rmw_fun_data_zero", 32'({arith_fun, rsp_data}), 32'd0);
        rst = 1'b0;
        #1;
        check("rmw_ready_after", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rmw_no_rsp", 32'({rsp_valid, arith_en}), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [1:0]    f;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            dly;
        bit            sup;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_fun   = 2'b00;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_ctrl", 32'({rsp_valid, arith_en, rsp_cout, rsp_err}), 32'd0);
        check("post_rst_ops", {in1, in2}, 32'd0);
        check("post_rst_data", 32'({arith_fun, rsp_data}), 32'd0);
        @(negedge clk);

        do_cmd(2'b00, 16'h1234, 16'h0001, 0, 1'b0, 0, 1'b1, 16'h1235, 1'b0);
        do_cmd(2'b00, 16'hFFFF, 16'h0001, 0, 1'b0, 1, 1'b1, 16'h0000, 1'b1);
        do_cmd(2'b01, 16'h0005, 16'h0007, 0, 1'b0, 0, 1'b1, 16'hFFFE, 1'b1);
        do_cmd(2'b11, 16'h0064, 16'h0000, 0, 1'b0, 1, 1'b1, 16'h0000, 1'b0);
        do_cmd(2'b11, 16'h0064, 16'h0005, 0, 1'b0, 0, 1'b1, 16'h0014, 1'b0);
        do_cmd(2'b10, 16'h0003, 16'h0004, 0, 1'b0, 5, 1'b1, 16'h000C, 1'b0);
        do_cmd(2'b00, 16'h0010, 16'h0020, 0, 1'b1, 2, 1'b1, 16'h0000, 1'b0);
        do_cmd(2'b00, 16'h0010, 16'h0020, 4, 1'b0, 3, 1'b1, 16'h0000, 1'b0);
        do_cmd(2'b00, 16'h0007, 16'h0008, 3, 1'b0, 0, 1'b1, 16'h000F, 1'b0);

        reset_mid_wait();
        do_cmd(2'b00, 16'h0002, 16'h0003, 0, 1'b0, 0, 1'b1, 16'h0005, 1'b0);

        for (int n = 0; n < 40; n++) begin
            f   = 2'($urandom);
            a   = DW'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            dly = $urandom_range(0, 5);
            sup = ($urandom_range(0, 7) == 0);
            do_cmd(f, a, b, dly, sup, $urandom_range(0, 3), 1'b0, '0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
